// File: rtl/exec_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit execute datapath.
// Decodes 16-bit instructions and times the clocked ALU and register writeback.
module exec_sequencer #(
  parameter int         EX_LAT = 1,
  parameter logic [3:0] MUL_OP = 4'h2,
  parameter logic [3:0] DIV_OP = 4'h3,
  parameter logic [3:0] JMP_OP = 4'hE,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr_data,
  input  logic [7:0]  alu_result,
  input  logic [15:0] alu_result_md,
  output logic [4:0]  instr_mem_addr,
  output logic        instr_rd_en,
  output logic [3:0]  opcode,
  output logic        am,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [4:0]  mem_addr,
  output logic        ex_enable,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_WB2,
    S_HALT
  } state_t;

  localparam logic [2:0] LAST = 3'(EX_LAT - 1);

  state_t      state;
  state_t      nstate;
  logic [4:0]  pc;
  logic [15:0] ir;
  logic [2:0]  cnt;
  logic [7:0]  res_q;
  logic [15:0] md_q;
  logic        is_md;
  logic [3:0]  new_op;

  assign opcode         = ir[15:12];
  assign am             = ir[11];
  assign rd             = ir[10:8];
  assign rs1            = ir[7:5];
  assign rs2            = ir[4:2];
  assign mem_addr       = ir[4:0];
  assign instr_mem_addr = pc;
  assign is_md          = (opcode == MUL_OP) || (opcode == DIV_OP);
  assign new_op         = instr_data[15:12];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  // PC, instruction register, EXEC counter and ALU result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
      res_q <= '0;
      md_q  <= '0;
    end else begin
      if (state == S_DECODE) begin
        ir  <= instr_data;
        cnt <= '0;
        if (new_op == JMP_OP) pc <= instr_data[4:0];
        else                  pc <= pc + 5'd1;
      end
      if (state == S_EXEC) begin
        if (cnt == LAST) begin
          res_q <= alu_result;
          md_q  <= alu_result_md;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

  // Next-state and control outputs
  always_comb begin
    nstate      = state;
    instr_rd_en = 1'b0;
    ex_enable   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    busy        = 1'b1;
    halted      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nstate = S_FETCH;
      end
      S_FETCH: begin
        instr_rd_en = 1'b1;
        nstate      = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (new_op == HLT_OP): nstate = S_HALT;
          (new_op == JMP_OP): nstate = S_FETCH;
          default:            nstate = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ex_enable = 1'b1;
        if (cnt == LAST) nstate = S_WB;
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_addr = rd;
        wr_data = is_md ? md_q[7:0] : res_q;
        nstate  = is_md ? S_WB2 : S_FETCH;
      end
      S_WB2: begin
        wr_en   = 1'b1;
        wr_addr = rd + 3'd1;
        wr_data = md_q[15:8];
        nstate  = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: nstate = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table-driven instruction vectors
// plus hand sequences for jump, wrap, halt and mid-EXEC reset.
module tb_exec_sequencer;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  res;
    logic [15:0] md;
    logic        two;
    logic [2:0]  a0;
    logic [7:0]  d0;
    logic [2:0]  a1;
    logic [7:0]  d1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  // EX_LAT=1 instance
  logic        reset1, start1;
  logic [15:0] idata1, md1;
  logic [7:0]  res1;
  logic [4:0]  addr1, maddr1;
  logic        rden1, am1, ex1, wr1, busy1, halt1;
  logic [3:0]  op1;
  logic [2:0]  rd1, rs11, rs21, wa1;
  logic [7:0]  wd1;
  logic [15:0] mem1 [32];
  logic [39:0] all1;

  // EX_LAT=4 instance
  logic        reset4, start4;
  logic [15:0] idata4, md4;
  logic [7:0]  res4;
  logic [4:0]  addr4, maddr4;
  logic        rden4, am4, ex4, wr4, busy4, halt4;
  logic [3:0]  op4;
  logic [2:0]  rd4, rs14, rs24, wa4;
  logic [7:0]  wd4;
  logic [15:0] mem4 [32];
  logic [39:0] all4;
  int          wr_seen4 = 0;

  exec_sequencer #(.EX_LAT(1)) u1 (
    .clk(clk), .reset(reset1), .start(start1),
    .instr_data(idata1), .alu_result(res1), .alu_result_md(md1),
    .instr_mem_addr(addr1), .instr_rd_en(rden1),
    .opcode(op1), .am(am1), .rd(rd1), .rs1(rs11), .rs2(rs21),
    .mem_addr(maddr1), .ex_enable(ex1), .wr_en(wr1),
    .wr_addr(wa1), .wr_data(wd1), .busy(busy1), .halted(halt1)
  );

  exec_sequencer #(.EX_LAT(4)) u4 (
    .clk(clk), .reset(reset4), .start(start4),
    .instr_data(idata4), .alu_result(res4), .alu_result_md(md4),
    .instr_mem_addr(addr4), .instr_rd_en(rden4),
    .opcode(op4), .am(am4), .rd(rd4), .rs1(rs14), .rs2(rs24),
    .mem_addr(maddr4), .ex_enable(ex4), .wr_en(wr4),
    .wr_addr(wa4), .wr_data(wd4), .busy(busy4), .halted(halt4)
  );

  assign all1 = {addr1, rden1, op1, am1, rd1, rs11, rs21, maddr1,
                 ex1, wr1, wa1, wd1, busy1, halt1};
  assign all4 = {addr4, rden4, op4, am4, rd4, rs14, rs24, maddr4,
                 ex4, wr4, wa4, wd4, busy4, halt4};

  always @(posedge clk) begin
    if (rden1) idata1 <= mem1[addr1];
    if (rden4) idata4 <= mem4[addr4];
    if (wr4) wr_seen4 <= wr_seen4 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ntotal++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      npass++;
  endtask

  // Runs one non-jump instruction on u1, entered at its FETCH cycle
  // and left at the following FETCH cycle.
  task automatic run_instr(input vec_t v, input logic [4:0] pc);
    chk("fetch_en", rden1, 1'b1);
    chk("fetch_addr", addr1, pc);
    res1 = v.res;
    md1  = v.md;
    tick();
    chk("dec_quiet", {ex1, wr1, busy1}, 3'b001);
    tick();
    chk("ex_en", {ex1, wr1}, 2'b10);
    chk("fields", {op1, am1, rd1, rs11, rs21}, v.instr[15:2]);
    chk("mem_addr", maddr1, v.instr[4:0]);
    tick();
    res1 = ~v.res;
    md1  = ~v.md;
    chk("wb", {ex1, wr1, wa1, wd1}, {1'b0, 1'b1, v.a0, v.d0});
    if (v.two) begin
      tick();
      chk("wb2", {ex1, wr1, wa1, wd1}, {1'b0, 1'b1, v.a1, v.d1});
    end
    tick();
  endtask

  vec_t tbl [4];
  vec_t v31;
  vec_t v2;

  initial begin
    tbl[0] = '{16'h1204, 8'h5A, 16'h0000, 1'b0, 3'd2, 8'h5A, 3'd0, 8'h00};
    tbl[1] = '{16'h2700, 8'h11, 16'hBEEF, 1'b1, 3'd7, 8'hEF, 3'd0, 8'hBE};
    tbl[2] = '{16'h3300, 8'h22, 16'h1234, 1'b1, 3'd3, 8'h34, 3'd4, 8'h12};
    tbl[3] = '{16'h4D1F, 8'hC3, 16'h0000, 1'b0, 3'd5, 8'hC3, 3'd0, 8'h00};
    v31    = '{16'h5600, 8'h99, 16'h0000, 1'b0, 3'd6, 8'h99, 3'd0, 8'h00};
    v2     = '{16'h1204, 8'h3C, 16'h0000, 1'b0, 3'd2, 8'h3C, 3'd0, 8'h00};

    for (int i = 0; i < 32; i++) begin
      mem1[i] = 16'hF000;
      mem4[i] = 16'hF000;
    end
    for (int i = 0; i < 4; i++) mem1[i] = tbl[i].instr;
    mem1[4]  = 16'hE01F;
    mem1[31] = v31.instr;
    mem4[0]  = 16'h1204;

    reset1 = 1'b0; start1 = 1'b0; res1 = '0; md1 = '0;
    reset4 = 1'b0; start4 = 1'b0; res4 = 8'h44; md4 = 16'h4444;

    // reset and idle
    repeat (3) tick();
    chk("in_reset", all1, 40'd0);
    reset1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", all1, 40'd0);
    end

    // table-driven program at 0..3
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) run_instr(tbl[i], 5'(i));

    // JMP to 31, ALU at 31, wrap to 0
    chk("jmp_fetch", {rden1, addr1}, {1'b1, 5'd4});
    tick();
    chk("jmp_dec", {ex1, wr1, busy1}, 3'b001);
    tick();
    run_instr(v31, 5'd31);
    chk("wrap_addr", {rden1, addr1}, {1'b1, 5'd0});

    // new program: JMP 5, JMP 2, ALU at 2, HLT at 3
    reset1 = 1'b0;
    mem1[0] = 16'hE005;
    mem1[5] = 16'hE002;
    mem1[2] = v2.instr;
    mem1[3] = 16'hF000;
    tick();
    chk("rst2", all1, 40'd0);
    reset1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("j5_fetch", {rden1, addr1}, {1'b1, 5'd0});
    tick();
    chk("j5_quiet", {ex1, wr1, rden1}, 3'b000);
    tick();
    chk("j5_target", {rden1, addr1}, {1'b1, 5'd5});
    tick();
    chk("j2_quiet", {ex1, wr1}, 2'b00);
    tick();
    run_instr(v2, 5'd2);
    chk("hlt_fetch", {rden1, addr1}, {1'b1, 5'd3});
    tick();
    chk("hlt_dec", {halt1, busy1}, 2'b01);
    tick();
    chk("halted", {halt1, busy1}, 2'b10);
    for (int i = 0; i < 10; i++) begin
      start1 = i[0];
      tick();
      chk("halt_stay", {halt1, busy1, rden1, ex1, wr1}, 5'b10000);
    end
    start1 = 1'b0;

    // EX_LAT=4 reset during EXEC
    reset4 = 1'b1;
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("r4_fetch", {rden4, addr4}, {1'b1, 5'd0});
    tick();
    tick();
    tick();
    chk("r4_exec", {ex4, wr4}, 2'b10);
    #3;
    reset4 = 1'b0;
    #1;
    chk("r4_async", all4, 40'd0);
    tick();
    tick();
    reset4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("r4_idle", all4, 40'd0);
    end
    chk("r4_nowrite", wr_seen4, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
